// File: rtl/fp_wb_arbiter_sp.sv
// fp_wb_arbiter_sp: writeback arbiter for the SP FP units feeding one registered output stage.
// Round-robin by default; define FP_WB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module fp_wb_arbiter_sp #(
    parameter int NUM_UNITS = 4,
    parameter int ID_W      = 3,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_UNITS-1:0]        unit_done,
    input  logic [NUM_UNITS*ID_W-1:0]   unit_id,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_rd,
    output logic [NUM_UNITS-1:0]        unit_ack,
    output logic                        wb_valid,
    output logic [ID_W-1:0]             wb_id,
    output logic [DATA_W-1:0]           wb_rd,
    output logic [$clog2(NUM_UNITS)-1:0] wb_unit,
    input  logic                        wb_ready
);
    localparam int UW = $clog2(NUM_UNITS);

    logic              wb_valid_q, wb_valid_d;
    logic [ID_W-1:0]   wb_id_q, wb_id_d;
    logic [DATA_W-1:0] wb_rd_q, wb_rd_d;
    logic [UW-1:0]     wb_unit_q, wb_unit_d;
    logic              advance, found, grant;
    logic [UW-1:0]     grant_idx;

    assign advance = !wb_valid_q || wb_ready;
    assign grant   = advance && found;

`ifdef FP_WB_FIXED_PRIO_EN
    // Unit 0 (div/sqrt) always wins so the slow pipe is never starved.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            if (unit_done[k]) begin
                found     = 1'b1;
                grant_idx = UW'(k);
            end
        end
    end
`else
    logic [UW-1:0] rr_q, rr_d;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!found && unit_done[(int'(rr_q) + k) % NUM_UNITS]) begin
                found     = 1'b1;
                grant_idx = UW'((int'(rr_q) + k) % NUM_UNITS);
            end
        end
        rr_d = !grant ? rr_q : (grant_idx == UW'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end
`endif

    always_comb begin
        wb_valid_d = advance ? found : wb_valid_q;
        wb_id_d    = grant ? unit_id[grant_idx*ID_W +: ID_W] : wb_id_q;
        wb_rd_d    = grant ? unit_rd[grant_idx*DATA_W +: DATA_W] : wb_rd_q;
        wb_unit_d  = grant ? grant_idx : wb_unit_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_id_q    <= '0;
            wb_rd_q    <= '0;
            wb_unit_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_id_q    <= wb_id_d;
            wb_rd_q    <= wb_rd_d;
            wb_unit_q  <= wb_unit_d;
        end
    end

    // Ack is suppressed asynchronously during reset so no unit drops a result.
    assign unit_ack = (rst_n && grant) ? (NUM_UNITS'(1) << grant_idx) : '0;
    assign wb_valid = wb_valid_q;
    assign wb_id    = wb_id_q;
    assign wb_rd    = wb_rd_q;
    assign wb_unit  = wb_unit_q;

`ifndef SYNTHESIS
    a_ack_onehot: assert property (@(posedge clk) $onehot0(unit_ack));
    a_ack_done:   assert property (@(posedge clk) (unit_ack & ~unit_done) == '0);
    a_wb_stable:  assert property (@(posedge clk) disable iff (!rst_n)
        wb_valid_q && !wb_ready |=> wb_valid_q && $stable({wb_id_q, wb_rd_q, wb_unit_q}));
`endif
endmodule

// File: tb/tb_fp_wb_arbiter_sp.sv
// tb_fp_wb_arbiter_sp: directed vector table plus reset sequences for fp_wb_arbiter_sp (default build).
module tb_fp_wb_arbiter_sp;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   unit_done;
    logic [11:0]  unit_id;
    logic [127:0] unit_rd;
    logic [3:0]   unit_ack;
    logic         wb_valid;
    logic [2:0]   wb_id;
    logic [31:0]  wb_rd;
    logic [1:0]   wb_unit;
    logic         wb_ready;
    int           n_chk = 0;
    int           n_fail = 0;

    localparam logic [11:0]  ID_DEF = {3'd4, 3'd3, 3'd2, 3'd1};
    localparam logic [11:0]  ID_ALT = {3'd4, 3'd5, 3'd2, 3'd1};
    localparam logic [127:0] RD_DEF = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    localparam logic [127:0] RD_ALT = {32'hC0DE0003, 32'h3F800000, 32'hC0DE0001, 32'hC0DE0000};

    fp_wb_arbiter_sp dut (
        .clk(clk), .rst_n(rst_n), .unit_done(unit_done), .unit_id(unit_id), .unit_rd(unit_rd),
        .unit_ack(unit_ack), .wb_valid(wb_valid), .wb_id(wb_id), .wb_rd(wb_rd),
        .wb_unit(wb_unit), .wb_ready(wb_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  done;
        logic        ready;
        logic        alt;
        logic [3:0]  ack;
        logic        valid;
        logic [2:0]  id;
        logic [31:0] rd;
        logic [1:0]  unit;
    } vec_t;

    vec_t tv[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic [2:0] id,
                          input logic [31:0] rd, input logic [1:0] u);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(v));
        chk({tag, ".wb_id"},    32'(wb_id),    32'(id));
        chk({tag, ".wb_rd"},    wb_rd,         rd);
        chk({tag, ".wb_unit"},  32'(wb_unit),  32'(u));
    endtask

    initial begin
        // drain, single source, drain, round-robin from rr=3, backpressure, refill, drain, wrap
        tv[0]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 3'd1, 32'hC0DE0000, 2'd0};
        tv[1]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, 3'd1, 32'hC0DE0000, 2'd0};
        tv[2]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 3'd5, 32'h3F800000, 2'd2};
        tv[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b0, 3'd5, 32'h3F800000, 2'd2};
        tv[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 3'd4, 32'hC0DE0003, 2'd3};
        tv[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 3'd1, 32'hC0DE0000, 2'd0};
        tv[6]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 3'd2, 32'hC0DE0001, 2'd1};
        tv[7]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 3'd3, 32'hC0DE0002, 2'd2};
        tv[8]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd4, 32'hC0DE0003, 2'd3};
        tv[9]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd4, 32'hC0DE0003, 2'd3};
        tv[10] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd4, 32'hC0DE0003, 2'd3};
        tv[11] = '{4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 3'd4, 32'hC0DE0003, 2'd3};
        tv[12] = '{4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1, 3'd1, 32'hC0DE0000, 2'd0};
        tv[13] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd2, 32'hC0DE0001, 2'd1};
        tv[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 3'd2, 32'hC0DE0001, 2'd1};
        tv[15] = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd2, 32'hC0DE0001, 2'd1};
        tv[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd1, 32'hC0DE0000, 2'd0};

        rst_n = 1'b0; unit_done = 4'b1111; wb_ready = 1'b1; unit_id = ID_DEF; unit_rd = RD_DEF;
        repeat (2) @(negedge clk);
        chk("rst.ack", 32'(unit_ack), 32'h0);
        chk_wb("rst", 1'b0, 3'd0, 32'h0, 2'd0);
        rst_n = 1'b1;
        #1 chk("rel.ack", 32'(unit_ack), 32'b0001);
        @(posedge clk);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            unit_done = tv[i].done;
            wb_ready  = tv[i].ready;
            unit_id   = tv[i].alt ? ID_ALT : ID_DEF;
            unit_rd   = tv[i].alt ? RD_ALT : RD_DEF;
            #1;
            chk($sformatf("v%0d.ack", i), 32'(unit_ack), 32'(tv[i].ack));
            chk_wb($sformatf("v%0d", i), tv[i].valid, tv[i].id, tv[i].rd, tv[i].unit);
        end

        // asynchronous reset between edges while a result is held
        @(negedge clk);
        unit_done = 4'b1111; wb_ready = 1'b0; unit_id = ID_DEF; unit_rd = RD_DEF;
        #1 chk("bp.ack", 32'(unit_ack), 32'h0);
        #1 rst_n = 1'b0;
        #1 chk("arst.ack", 32'(unit_ack), 32'h0);
        chk_wb("arst", 1'b0, 3'd0, 32'h0, 2'd0);
        wb_ready = 1'b1;
        #1 chk("arst.ack_ready", 32'(unit_ack), 32'h0);
        @(posedge clk);
        #1 chk("arst.hold_ack", 32'(unit_ack), 32'h0);
        chk("arst.hold_valid", 32'(wb_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arel.ack", 32'(unit_ack), 32'b0001);
        @(posedge clk);
        #1 chk_wb("arel", 1'b1, 3'd1, 32'hC0DE0000, 2'd0);
        chk("arel.ack2", 32'(unit_ack), 32'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
